pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the parameter BUS_TIMEOUT, default 16, meaning the maximum number of memory-wait cycles before the block forces release.
REQ-002 The block SHALL have the port clk  in  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have the port rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have the ports de_rs1_addr, de_rs2_addr  in  5 each  source registers of the instruction in decode.
REQ-005 The block SHALL have the ports de_rs1_used, de_rs2_used  in  1 each  the decode instruction reads rs1/rs2.
REQ-006 The block SHALL have the ports alu_is_load  in  1, alu_wr_reg_en  in  1, alu_wr_reg_addr  in  5, describing the instruction in the ALU stage.
REQ-007 The block SHALL have the port div_start  in  1  ALU stage launches a multi-cycle divide.
REQ-008 The block SHALL have the port div_done  in  1  divider result valid (1-cycle pulse).
REQ-009 The block SHALL have the ports mem_req  in  1 and mem_ack  in  1  for the memory-stage bus request and completion.
REQ-010 The block SHALL have the ports jump_flag  in  1 and jump_addr  in  32  for a taken branch/jump resolved in the ALU stage.
REQ-011 The block SHALL have the port stall  out  6  per-stage hold: [0] PC, [1] IF/DE, [2] DE/ALU, [3] ALU/MEM, [4] MEM/WB, [5] WB.
REQ-012 The block SHALL have the ports flush  out  1 and flush_pc  out  32  to redirect the PC and clear IF/DE and DE/ALU.
REQ-013 The block SHALL have the port bus_err  out  1  registered 1-cycle pulse on bus timeout.
REQ-014 The block SHALL have the port stall_cycles  out  32  count of cycles with any stall bit set.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, DIV_WAIT, BUS_WAIT.
REQ-016 stall, flush and flush_pc SHALL be combinational from FSM state and current inputs (same-cycle effect); bus_err and stall_cycles SHALL be registered.
REQ-017 Stall values are fixed: bus wait 6'b011111; divide 6'b001111; load-use 6'b000111; none 6'b000000. Downstream registers insert a bubble where stall[k]=1 and stall[k+1]=0.
REQ-018 Priority, highest first: bus wait, divide, flush, load-use.
REQ-019 Bus wait: mem_req=1 and mem_ack=0 in IDLE SHALL assert 011111 in that cycle and enter BUS_WAIT with wait counter=1.
REQ-020 In BUS_WAIT: mem_ack=1 SHALL drop the stall in that cycle and return to IDLE; otherwise the counter increments; on the cycle the counter equals BUS_TIMEOUT, the stall SHALL drop, the FSM SHALL return to IDLE, and bus_err SHALL pulse high on the next cycle.
REQ-021 mem_req=1 with mem_ack=1 in the same cycle in IDLE SHALL cause no stall.
REQ-022 Divide: div_start=1 in IDLE with no bus wait SHALL assert 001111 in that cycle and enter DIV_WAIT.
REQ-023 In DIV_WAIT, 001111 SHALL hold until div_done=1; in that cycle the stall SHALL drop and the FSM SHALL return to IDLE.
REQ-024 A bus wait arising during DIV_WAIT SHALL override the stall to 011111 while the FSM remains in DIV_WAIT.
REQ-025 div_start arriving together with a bus wait SHALL be ignored; it is re-presented because the ALU stage is held.
REQ-026 A load-use hazard SHALL be detected when alu_is_load and alu_wr_reg_en are 1, alu_wr_reg_addr is not 0, and it matches (de_rs1_addr with de_rs1_used) or (de_rs2_addr with de_rs2_used); it SHALL produce 000111 for that cycle only.
REQ-027 flush SHALL equal jump_flag AND NOT stall[3]; when flush is 1, flush_pc SHALL equal jump_addr, else 0.
REQ-028 flush SHALL suppress any load-use stall in the same cycle.
REQ-029 stall_cycles SHALL increment when stall is not 0 and wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 When rst=1 at a rising edge: FSM SHALL go to IDLE, wait counter 0, bus_err 0, stall_cycles 0.
REQ-031 While rst=1, stall SHALL be 0, flush SHALL be 0 and flush_pc SHALL be 0, regardless of inputs.
REQ-032 Reset asserted mid-DIV_WAIT or mid-BUS_WAIT SHALL abort the wait with no bus_err pulse.

Verification
REQ-033 Load-use: alu_is_load=1, alu_wr_reg_en=1, alu_wr_reg_addr=5, de_rs2_addr=5, de_rs2_used=1 -> stall=000111 for exactly 1 cycle; with address 0 -> stall=000000.
REQ-034 Divide: div_start pulse, div_done 8 cycles later -> stall=001111 for 8 cycles, then 000000; FSM is IDLE afterwards.
REQ-035 Bus timeout: mem_req=1 with mem_ack held at 0 -> stall=011111 for 16 cycles, bus_err=1 on the next cycle only.
REQ-036 Conflict: jump_flag=1 with jump_addr=0x80000040 while a bus wait is active -> flush=0; when mem_ack=1 -> flush=1 and flush_pc=0x80000040.
REQ-037 Jump and load-use in the same cycle -> flush=1, stall=000000.
REQ-038 Counter: preload stall_cycles to 0xFFFFFFFF, apply one stall cycle -> stall_cycles=0; apply rst during DIV_WAIT -> stall=0 and no bus_err pulse.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline hazard controller for a 5-stage in-order core.
//             Produces per-stage hold vectors for memory-bus waits,
//             multi-cycle divides and load-use hazards, redirects the PC
//             on taken jumps, flags bus timeouts and counts stalled cycles.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             de_rs*_addr/_used        - source operands of decode instruction
//             alu_is_load/_wr_reg_*    - destination info of ALU instruction
//             div_start, div_done      - multi-cycle divider handshake
//             mem_req, mem_ack         - memory-stage bus request/completion
//             jump_flag, jump_addr     - taken branch/jump from ALU stage
//             stall[5:0]               - hold: PC, IF/DE, DE/ALU, ALU/MEM,
//                                        MEM/WB, WB
//             flush, flush_pc          - PC redirect and front-end clear
//             bus_err                  - 1-cycle pulse after bus timeout
//             stall_cycles             - count of cycles with any stall
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  de_rs1_addr,
    input  logic [4:0]  de_rs2_addr,
    input  logic        de_rs1_used,
    input  logic        de_rs2_used,
    input  logic        alu_is_load,
    input  logic        alu_wr_reg_en,
    input  logic [4:0]  alu_wr_reg_addr,
    input  logic        div_start,
    input  logic        div_done,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        bus_err,
    output logic [31:0] stall_cycles
);

    localparam int              CNT_W       = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(BUS_TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [5:0]      C_STALL_BUS  = 6'b011111;
    localparam logic [5:0]      C_STALL_DIV  = 6'b001111;
    localparam logic [5:0]      C_STALL_LU   = 6'b000111;
    localparam logic [5:0]      C_STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_WAIT = 2'd1,
        S_BUS_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               bus_err_q, bus_err_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;

    logic               bus_wait;
    logic               load_use;
    logic [5:0]         hold;

    // A bus request is still outstanding when it has not been acknowledged
    // in the same cycle.
    assign bus_wait = mem_req & ~mem_ack;

    // Register x0 never creates a dependency.
    assign load_use = alu_is_load & alu_wr_reg_en & (alu_wr_reg_addr != 5'd0) &
                      ((de_rs1_used & (de_rs1_addr == alu_wr_reg_addr)) |
                       (de_rs2_used & (de_rs2_addr == alu_wr_reg_addr)));

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        bus_err_d      = 1'b0;
        hold           = C_STALL_NONE;
        stall          = C_STALL_NONE;
        flush          = 1'b0;
        flush_pc       = 32'd0;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            S_IDLE: begin
                // A bus wait outranks a divide launch; the held ALU stage
                // re-presents div_start once the bus completes.
                if (bus_wait) begin
                    hold       = C_STALL_BUS;
                    state_d    = S_BUS_WAIT;
                    wait_cnt_d = C_CNT_ONE;
                end else if (div_start) begin
                    hold    = C_STALL_DIV;
                    state_d = S_DIV_WAIT;
                end
            end
            S_DIV_WAIT: begin
                // A bus wait only widens the hold; the divide keeps
                // running, so the state stays put.
                if (div_done) begin
                    state_d = S_IDLE;
                end
                if (bus_wait) begin
                    hold = C_STALL_BUS;
                end else if (!div_done) begin
                    hold = C_STALL_DIV;
                end
            end
            S_BUS_WAIT: begin
                if (mem_ack) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == C_TIMEOUT) begin
                    // Force release; the error pulse appears next cycle.
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                    bus_err_d  = 1'b1;
                end else begin
                    hold       = C_STALL_BUS;
                    wait_cnt_d = wait_cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase

        stall = hold;
        // A jump can only redirect when ALU/MEM is moving; a redirect kills
        // the decode instruction, so its load-use stall is moot.
        if (jump_flag && !hold[3]) begin
            flush    = 1'b1;
            flush_pc = jump_addr;
        end else if (hold == C_STALL_NONE && load_use) begin
            stall = C_STALL_LU;
        end

        if (rst) begin
            stall    = C_STALL_NONE;
            flush    = 1'b0;
            flush_pc = 32'd0;
        end

        if (stall != C_STALL_NONE) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wait_cnt_q     <= '0;
            bus_err_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            bus_err_q      <= bus_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus_err      = bus_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl. Expected combinational
//             outputs are queued as each cycle's stimulus is applied and
//             popped for comparison; registered outputs are checked after
//             the clock edge against a small reference count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  de_rs1_addr, de_rs2_addr;
    logic        de_rs1_used, de_rs2_used;
    logic        alu_is_load, alu_wr_reg_en;
    logic [4:0]  alu_wr_reg_addr;
    logic        div_start, div_done;
    logic        mem_req, mem_ack;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        bus_err;
    logic [31:0] stall_cycles;

    typedef struct {
        string       tag;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_cnt = 32'd0;

    pipe_ctrl #(.BUS_TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .de_rs1_addr     (de_rs1_addr),
        .de_rs2_addr     (de_rs2_addr),
        .de_rs1_used     (de_rs1_used),
        .de_rs2_used     (de_rs2_used),
        .alu_is_load     (alu_is_load),
        .alu_wr_reg_en   (alu_wr_reg_en),
        .alu_wr_reg_addr (alu_wr_reg_addr),
        .div_start       (div_start),
        .div_done        (div_done),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .jump_flag       (jump_flag),
        .jump_addr       (jump_addr),
        .stall           (stall),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .bus_err         (bus_err),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clr_inputs();
        de_rs1_addr = 5'd0; de_rs2_addr = 5'd0;
        de_rs1_used = 1'b0; de_rs2_used = 1'b0;
        alu_is_load = 1'b0; alu_wr_reg_en = 1'b0; alu_wr_reg_addr = 5'd0;
        div_start = 1'b0; div_done = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
        jump_flag = 1'b0; jump_addr = 32'd0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic u1, input logic [4:0] rs2, input logic u2);
        alu_is_load = 1'b1; alu_wr_reg_en = 1'b1; alu_wr_reg_addr = rd;
        de_rs1_addr = rs1; de_rs1_used = u1;
        de_rs2_addr = rs2; de_rs2_used = u2;
    endtask

    // Called at a falling edge with the cycle's inputs already driven.
    task automatic tick(input string tag, input logic [5:0] st, input logic fl,
                        input logic [31:0] pc, input logic be_next);
        exp_t e;
        exp_q.push_back('{tag, st, fl, pc});
        #1;
        e = exp_q.pop_front();
        check_val({e.tag, ".stall"},    {26'd0, stall}, {26'd0, e.st});
        check_val({e.tag, ".flush"},    {31'd0, flush}, {31'd0, e.fl});
        check_val({e.tag, ".flush_pc"}, flush_pc,       e.pc);
        if (rst)             model_cnt = 32'd0;
        else if (e.st != 0)  model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
        check_val({tag, ".bus_err"},      {31'd0, bus_err}, {31'd0, be_next});
        check_val({tag, ".stall_cycles"}, stall_cycles,     model_cnt);
        @(negedge clk);
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        @(negedge clk);

        // Outputs stay quiet under reset whatever the inputs say.
        jump_flag = 1'b1; jump_addr = 32'h1234_5678; mem_req = 1'b1;
        set_load_use(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        tick("rst_quiet", 6'b000000, 1'b0, 32'd0, 1'b0);
        clr_inputs();
        tick("rst_idle", 6'b000000, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        tick("idle", 6'b000000, 1'b0, 32'd0, 1'b0);

        // Load-use hazards
        set_load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        tick("lu_rs2", 6'b000111, 1'b0, 32'd0, 1'b0);
        clr_inputs();
        tick("lu_after", 6'b000000, 1'b0, 32'd0, 1'b0);
        set_load_use(5'd9, 5'd9, 1'b1, 5'd1, 1'b1);
        tick("lu_rs1", 6'b000111, 1'b0, 32'd0, 1'b0);
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        tick("lu_x0", 6'b000000, 1'b0, 32'd0, 1'b0);
        set_load_use(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        tick("lu_unused", 6'b000000, 1'b0, 32'd0, 1'b0);
        clr_inputs();

        // Divide: done eight cycles after start
        div_start = 1'b1;
        tick("div_start", 6'b001111, 1'b0, 32'd0, 1'b0);
        div_start = 1'b0;
        for (int i = 1; i < 8; i++) tick("div_wait", 6'b001111, 1'b0, 32'd0, 1'b0);
        div_done = 1'b1;
        tick("div_done", 6'b000000, 1'b0, 32'd0, 1'b0);
        div_done = 1'b0;
        set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        tick("div_idle_lu", 6'b000111, 1'b0, 32'd0, 1'b0);
        clr_inputs();

        // Bus wait overriding an ongoing divide
        div_start = 1'b1;
        tick("dbus_start", 6'b001111, 1'b0, 32'd0, 1'b0);
        div_start = 1'b0; mem_req = 1'b1;
        tick("dbus_override", 6'b011111, 1'b0, 32'd0, 1'b0);
        mem_req = 1'b0;
        tick("dbus_back", 6'b001111, 1'b0, 32'd0, 1'b0);
        div_done = 1'b1;
        tick("dbus_done", 6'b000000, 1'b0, 32'd0, 1'b0);
        clr_inputs();

        // Bus timeout
        mem_req = 1'b1;
        for (int i = 0; i < 16; i++) tick("bus_wait", 6'b011111, 1'b0, 32'd0, 1'b0);
        tick("bus_timeout", 6'b000000, 1'b0, 32'd0, 1'b1);
        mem_req = 1'b0;
        tick("bus_err_once", 6'b000000, 1'b0, 32'd0, 1'b0);

        // Same-cycle ack, and div_start dropped under a bus wait
        mem_req = 1'b1; mem_ack = 1'b1;
        tick("req_ack", 6'b000000, 1'b0, 32'd0, 1'b0);
        mem_ack = 1'b0; div_start = 1'b1;
        tick("div_vs_bus", 6'b011111, 1'b0, 32'd0, 1'b0);
        div_start = 1'b0; mem_ack = 1'b1;
        tick("div_vs_bus_ack", 6'b000000, 1'b0, 32'd0, 1'b0);
        clr_inputs();
        tick("div_ignored", 6'b000000, 1'b0, 32'd0, 1'b0);

        // Jump against an active bus wait
        mem_req = 1'b1; jump_flag = 1'b1; jump_addr = 32'h8000_0040;
        tick("jmp_blocked", 6'b011111, 1'b0, 32'd0, 1'b0);
        mem_ack = 1'b1;
        tick("jmp_on_ack", 6'b000000, 1'b1, 32'h8000_0040, 1'b0);
        clr_inputs();

        // Jump beats load-use
        set_load_use(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        jump_flag = 1'b1; jump_addr = 32'h0000_2000;
        tick("jmp_lu", 6'b000000, 1'b1, 32'h0000_2000, 1'b0);
        clr_inputs();

        // Counter wrap
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        model_cnt = 32'hFFFF_FFFF;
        set_load_use(5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
        tick("cnt_wrap", 6'b000111, 1'b0, 32'd0, 1'b0);
        clr_inputs();

        // Reset in the middle of a divide
        div_start = 1'b1;
        tick("rdiv_start", 6'b001111, 1'b0, 32'd0, 1'b0);
        div_start = 1'b0;
        tick("rdiv_wait", 6'b001111, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        tick("rdiv_rst", 6'b000000, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        tick("rdiv_after", 6'b000000, 1'b0, 32'd0, 1'b0);
        set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        tick("rdiv_idle_lu", 6'b000111, 1'b0, 32'd0, 1'b0);
        clr_inputs();

        // Reset landing on the timeout cycle of a bus wait
        mem_req = 1'b1;
        for (int i = 0; i < 16; i++) tick("rbus_wait", 6'b011111, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        tick("rbus_rst", 6'b000000, 1'b0, 32'd0, 1'b0);
        rst = 1'b0; mem_req = 1'b0;
        tick("rbus_no_err", 6'b000000, 1'b0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
